// File: rtl/ex_muldiv_if.sv
// Execute-stage bundle between the ID/EX register and the MEM stage.
// master: the upstream/downstream pipeline side. slave: the execute unit.
interface ex_muldiv_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OP_W       = 8
);
    logic                  valid_i;
    logic [OP_W-1:0]       aluop_i;
    logic [XLEN-1:0]       reg1_i;
    logic [XLEN-1:0]       reg2_i;
    logic [REG_ADDR_W-1:0] wd_i;
    logic                  wreg_i;
    logic                  flush_i;
    logic                  stall_req_o;
    logic                  valid_o;
    logic [REG_ADDR_W-1:0] wd_o;
    logic                  wreg_o;
    logic [XLEN-1:0]       wdata_o;

    modport master (
        output valid_i, aluop_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
        input  stall_req_o, valid_o, wd_o, wreg_o, wdata_o
    );

    modport slave (
        input  valid_i, aluop_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
        output stall_req_o, valid_o, wd_o, wreg_o, wdata_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// Execute stage: single-cycle RV32I ALU plus an iterative M-extension unit
// (radix-2 shift-add multiply, restoring divide). Results are registered;
// a combinational stall request freezes upstream while mul/div iterates.
module ex_muldiv #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OP_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);
    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [OP_W-1:0] OP_ADD    = OP_W'(8'h01);
    localparam logic [OP_W-1:0] OP_SUB    = OP_W'(8'h02);
    localparam logic [OP_W-1:0] OP_AND    = OP_W'(8'h03);
    localparam logic [OP_W-1:0] OP_OR     = OP_W'(8'h04);
    localparam logic [OP_W-1:0] OP_XOR    = OP_W'(8'h05);
    localparam logic [OP_W-1:0] OP_SLL    = OP_W'(8'h06);
    localparam logic [OP_W-1:0] OP_SRL    = OP_W'(8'h07);
    localparam logic [OP_W-1:0] OP_SRA    = OP_W'(8'h08);
    localparam logic [OP_W-1:0] OP_SLT    = OP_W'(8'h09);
    localparam logic [OP_W-1:0] OP_SLTU   = OP_W'(8'h0A);
    localparam logic [OP_W-1:0] OP_MUL    = OP_W'(8'h10);
    localparam logic [OP_W-1:0] OP_MULH   = OP_W'(8'h11);
    localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(8'h12);
    localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(8'h13);
    localparam logic [OP_W-1:0] OP_DIV    = OP_W'(8'h14);
    localparam logic [OP_W-1:0] OP_DIVU   = OP_W'(8'h15);
    localparam logic [OP_W-1:0] OP_REM    = OP_W'(8'h16);
    localparam logic [OP_W-1:0] OP_REMU   = OP_W'(8'h17);

    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t                state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    // hi half: product high / partial remainder; lo half: multiplier / quotient
    logic [2*XLEN-1:0]     acc_reg;
    // multiplicand magnitude or divisor magnitude
    logic [XLEN-1:0]       opnd_reg;
    logic                  neg_reg;
    logic [OP_W-1:0]       op_reg;
    logic [REG_ADDR_W-1:0] wd_hold_reg;
    logic                  wreg_hold_reg;
    logic                  valid_reg;
    logic                  wreg_reg;
    logic [REG_ADDR_W-1:0] wd_reg;
    logic [XLEN-1:0]       wdata_reg;

    logic                  is_m, is_div, is_rem, a_neg, b_neg;
    logic                  div_zero, div_ovf, neg_next;
    logic [XLEN-1:0]       a_mag, b_mag, alu_next;
    logic [2*XLEN-1:0]     mul_next, div_next, prod_signed;
    logic [XLEN:0]         mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]       div_word, done_next;

    assign bus.valid_o = valid_reg;
    assign bus.wreg_o  = wreg_reg;
    assign bus.wd_o    = wd_reg;
    assign bus.wdata_o = wdata_reg;

    // Freeze upstream from M-op issue until the iteration finishes.
    assign bus.stall_req_o = (state_reg == S_MUL) || (state_reg == S_DIV) ||
                             ((state_reg == S_IDLE) && bus.valid_i && is_m);

    // Decode the incoming op: class, operand signedness, magnitudes, div corner cases.
    always_comb begin
        is_m     = (bus.aluop_i >= OP_MUL) && (bus.aluop_i <= OP_REMU);
        is_div   = is_m && (bus.aluop_i >= OP_DIV);
        is_rem   = (bus.aluop_i == OP_REM) || (bus.aluop_i == OP_REMU);
        a_neg    = bus.reg1_i[XLEN-1] &&
                   ((bus.aluop_i == OP_MUL) || (bus.aluop_i == OP_MULH) ||
                    (bus.aluop_i == OP_MULHSU) || (bus.aluop_i == OP_DIV) ||
                    (bus.aluop_i == OP_REM));
        b_neg    = bus.reg2_i[XLEN-1] &&
                   ((bus.aluop_i == OP_MUL) || (bus.aluop_i == OP_MULH) ||
                    (bus.aluop_i == OP_DIV) || (bus.aluop_i == OP_REM));
        a_mag    = a_neg ? -bus.reg1_i : bus.reg1_i;
        b_mag    = b_neg ? -bus.reg2_i : bus.reg2_i;
        // Remainder follows the dividend; product and quotient follow the xor.
        neg_next = is_rem ? a_neg : (a_neg ^ b_neg);
        div_zero = (bus.reg2_i == '0);
        div_ovf  = ((bus.aluop_i == OP_DIV) || (bus.aluop_i == OP_REM)) &&
                   (bus.reg1_i == XMIN) && (bus.reg2_i == '1);
    end

    // Single-cycle ALU result; NOP and unknown opcodes yield zero.
    always_comb begin
        alu_next = '0;
        case (bus.aluop_i)
            OP_ADD:  alu_next = bus.reg1_i + bus.reg2_i;
            OP_SUB:  alu_next = bus.reg1_i - bus.reg2_i;
            OP_AND:  alu_next = bus.reg1_i & bus.reg2_i;
            OP_OR:   alu_next = bus.reg1_i | bus.reg2_i;
            OP_XOR:  alu_next = bus.reg1_i ^ bus.reg2_i;
            OP_SLL:  alu_next = bus.reg1_i << bus.reg2_i[SH_W-1:0];
            OP_SRL:  alu_next = bus.reg1_i >> bus.reg2_i[SH_W-1:0];
            OP_SRA:  alu_next = $unsigned($signed(bus.reg1_i) >>> bus.reg2_i[SH_W-1:0]);
            OP_SLT:  alu_next = {{(XLEN-1){1'b0}}, ($signed(bus.reg1_i) < $signed(bus.reg2_i))};
            OP_SLTU: alu_next = {{(XLEN-1){1'b0}}, (bus.reg1_i < bus.reg2_i)};
            default: alu_next = '0;
        endcase
    end

    // One iteration step of each engine, and the final sign fix-up / word select.
    always_comb begin
        mul_sum     = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
        mul_next    = {mul_sum, acc_reg[XLEN-1:1]};
        div_shift   = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
        div_diff    = div_shift - {1'b0, opnd_reg};
        div_next    = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
        prod_signed = neg_reg ? -acc_reg : acc_reg;
        div_word    = ((op_reg == OP_REM) || (op_reg == OP_REMU)) ?
                      acc_reg[2*XLEN-1:XLEN] : acc_reg[XLEN-1:0];
        if (neg_reg) div_word = -div_word;
        if (op_reg == OP_MUL)
            done_next = prod_signed[XLEN-1:0];
        else if (op_reg < OP_DIV)
            done_next = prod_signed[2*XLEN-1:XLEN];
        else
            done_next = div_word;
    end

    // Control FSM with registered outputs; flush and reset both return to IDLE.
    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            opnd_reg      <= '0;
            neg_reg       <= 1'b0;
            op_reg        <= '0;
            wd_hold_reg   <= '0;
            wreg_hold_reg <= 1'b0;
            valid_reg     <= 1'b0;
            wreg_reg      <= 1'b0;
            wd_reg        <= '0;
            wdata_reg     <= '0;
        end else begin
            valid_reg <= 1'b0;
            wreg_reg  <= 1'b0;
            wd_reg    <= '0;
            wdata_reg <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.valid_i && is_m) begin
                        op_reg        <= bus.aluop_i;
                        wd_hold_reg   <= bus.wd_i;
                        wreg_hold_reg <= bus.wreg_i;
                        opnd_reg      <= b_mag;
                        neg_reg       <= neg_next;
                        cnt_reg       <= CNT_W'(XLEN);
                        if (!is_div) begin
                            acc_reg   <= {{XLEN{1'b0}}, a_mag};
                            state_reg <= S_MUL;
                        end else if (div_zero) begin
                            // remainder = raw dividend, quotient = all ones
                            acc_reg   <= {bus.reg1_i, {XLEN{1'b1}}};
                            neg_reg   <= 1'b0;
                            cnt_reg   <= '0;
                            state_reg <= S_DONE;
                        end else if (div_ovf) begin
                            acc_reg   <= {{XLEN{1'b0}}, XMIN};
                            neg_reg   <= 1'b0;
                            cnt_reg   <= '0;
                            state_reg <= S_DONE;
                        end else begin
                            acc_reg   <= {{XLEN{1'b0}}, a_mag};
                            state_reg <= S_DIV;
                        end
                    end else if (bus.valid_i) begin
                        valid_reg <= 1'b1;
                        wreg_reg  <= bus.wreg_i;
                        wd_reg    <= bus.wd_i;
                        wdata_reg <= alu_next;
                    end
                end
                S_MUL: begin
                    acc_reg <= mul_next;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1)) state_reg <= S_DONE;
                end
                S_DIV: begin
                    acc_reg <= div_next;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1)) state_reg <= S_DONE;
                end
                S_DONE: begin
                    valid_reg <= 1'b1;
                    wreg_reg  <= wreg_hold_reg;
                    wd_reg    <= wd_hold_reg;
                    wdata_reg <= done_next;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: vector table for ALU/M ops with latency and
// stall-cycle checks, plus flush, mid-op reset and an XLEN=8 instance.
module tb_ex_muldiv;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_muldiv_if #(.XLEN(32), .REG_ADDR_W(5), .OP_W(8)) bus ();
    ex_muldiv_if #(.XLEN(8),  .REG_ADDR_W(5), .OP_W(8)) bus8 ();

    ex_muldiv #(.XLEN(32), .REG_ADDR_W(5), .OP_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    ex_muldiv #(.XLEN(8),  .REG_ADDR_W(5), .OP_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] exp;
        int          lat;
        int          stalls;
    } vec_t;

    vec_t vecs[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] wd, input logic wreg, input logic [31:0] exp,
                                input int lat, input int stalls);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.wd = wd; v.wreg = wreg;
        v.exp = exp; v.lat = lat; v.stalls = stalls;
        vecs.push_back(v);
    endfunction

    // Issue one instruction, hold it while stalled, wait for valid_o.
    task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wd, input logic wreg,
                          output int lat, output int stalls, output logic [31:0] data,
                          output logic [4:0] wd_out, output logic wreg_out, output logic got);
        logic st;
        bus.valid_i = 1'b1; bus.aluop_i = op; bus.reg1_i = a; bus.reg2_i = b;
        bus.wd_i = wd; bus.wreg_i = wreg;
        lat = 0; stalls = 0; got = 1'b0; data = '0; wd_out = '0; wreg_out = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            st = bus.stall_req_o;
            if (st) stalls++;
            @(posedge clk); #1;
            lat++;
            if (!st) begin
                bus.valid_i = 1'b0; bus.aluop_i = '0;
            end
            if (bus.valid_o) begin
                got = 1'b1; data = bus.wdata_o; wd_out = bus.wd_o; wreg_out = bus.wreg_o;
            end
        end
        bus.valid_i = 1'b0;
    endtask

    initial begin
        int lat, stalls, spurious;
        logic [31:0] data;
        logic [4:0] wdo;
        logic wro, got, st;

        bus.valid_i = 0; bus.aluop_i = 0; bus.reg1_i = 0; bus.reg2_i = 0;
        bus.wd_i = 0; bus.wreg_i = 0; bus.flush_i = 0;
        bus8.valid_i = 0; bus8.aluop_i = 0; bus8.reg1_i = 0; bus8.reg2_i = 0;
        bus8.wd_i = 0; bus8.wreg_i = 0; bus8.flush_i = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid_o", {31'b0, bus.valid_o}, 32'd0);
        chk("reset wreg_o", {31'b0, bus.wreg_o}, 32'd0);
        chk("reset wd_o", {27'b0, bus.wd_o}, 32'd0);
        chk("reset wdata_o", bus.wdata_o, 32'd0);
        chk("reset stall", {31'b0, bus.stall_req_o}, 32'd0);
        rst = 1'b0;

        // ALU: latency 1, no stall
        add(8'h04, 32'hF0F0_0000, 32'h0000_0F0F, 5'd5, 1'b1, 32'hF0F0_0F0F, 1, 0);
        add(8'h08, 32'h8000_0000, 32'd4,         5'd6, 1'b1, 32'hF800_0000, 1, 0);
        add(8'h01, 32'hFFFF_FFFF, 32'd2,         5'd7, 1'b1, 32'h0000_0001, 1, 0);
        add(8'h02, 32'd5,         32'd7,         5'd8, 1'b1, 32'hFFFF_FFFE, 1, 0);
        add(8'h03, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd9, 1'b0, 32'h0F00_0F00, 1, 0);
        add(8'h05, 32'hAAAA_5555, 32'hFFFF_0000, 5'd10, 1'b1, 32'h5555_5555, 1, 0);
        add(8'h06, 32'd1,         32'h0000_003F, 5'd11, 1'b1, 32'h8000_0000, 1, 0);
        add(8'h07, 32'h8000_0000, 32'd4,         5'd12, 1'b1, 32'h0800_0000, 1, 0);
        add(8'h09, 32'hFFFF_FFFF, 32'd1,         5'd13, 1'b1, 32'h0000_0001, 1, 0);
        add(8'h0A, 32'hFFFF_FFFF, 32'd1,         5'd14, 1'b1, 32'h0000_0000, 1, 0);
        add(8'h20, 32'h1234_5678, 32'h1,         5'd15, 1'b1, 32'h0000_0000, 1, 0);
        // multiply: 33 stall cycles, result 34 cycles after issue
        add(8'h11, 32'hFFFF_FFFD, 32'd5,         5'd16, 1'b1, 32'hFFFF_FFFF, 34, 33);
        add(8'h10, 32'hFFFF_FFFD, 32'd5,         5'd17, 1'b1, 32'hFFFF_FFF1, 34, 33);
        add(8'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18, 1'b1, 32'hFFFF_FFFE, 34, 33);
        add(8'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd19, 1'b1, 32'hFFFF_FFFF, 34, 33);
        // divide
        add(8'h14, 32'hFFFF_FFF9, 32'd2,         5'd20, 1'b1, 32'hFFFF_FFFD, 34, 33);
        add(8'h16, 32'hFFFF_FFF9, 32'd2,         5'd21, 1'b1, 32'hFFFF_FFFF, 34, 33);
        add(8'h15, 32'd100,       32'd7,         5'd22, 1'b1, 32'd14,        34, 33);
        add(8'h17, 32'd100,       32'd7,         5'd23, 1'b0, 32'd2,         34, 33);
        add(8'h14, 32'd7,         32'hFFFF_FFFE, 5'd24, 1'b1, 32'hFFFF_FFFD, 34, 33);
        add(8'h16, 32'd7,         32'hFFFF_FFFE, 5'd25, 1'b1, 32'd1,         34, 33);
        // special-case divides: one stall cycle, result 2 cycles after issue
        add(8'h15, 32'd9,         32'd0,         5'd26, 1'b1, 32'hFFFF_FFFF, 2, 1);
        add(8'h17, 32'd9,         32'd0,         5'd27, 1'b1, 32'd9,         2, 1);
        add(8'h14, 32'hFFFF_FFFB, 32'd0,         5'd28, 1'b1, 32'hFFFF_FFFF, 2, 1);
        add(8'h16, 32'hFFFF_FFFB, 32'd0,         5'd29, 1'b1, 32'hFFFF_FFFB, 2, 1);
        add(8'h14, 32'h8000_0000, 32'hFFFF_FFFF, 5'd30, 1'b1, 32'h8000_0000, 2, 1);
        add(8'h16, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 1'b1, 32'd0,         2, 1);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wd, vecs[i].wreg,
                   lat, stalls, data, wdo, wro, got);
            $display("vec %0d op=%h a=%h b=%h -> wdata=%h lat=%0d stalls=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, data, lat, stalls);
            chk($sformatf("vec%0d valid", i), {31'b0, got}, 32'd1);
            chk($sformatf("vec%0d wdata", i), data, vecs[i].exp);
            chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d stalls", i), stalls, vecs[i].stalls);
            chk($sformatf("vec%0d wd_o", i), {27'b0, wdo}, {27'b0, vecs[i].wd});
            chk($sformatf("vec%0d wreg_o", i), {31'b0, wro}, {31'b0, vecs[i].wreg});
        end

        // flush at iteration 10 of a DIVU
        bus.valid_i = 1'b1; bus.aluop_i = 8'h15; bus.reg1_i = 32'd100; bus.reg2_i = 32'd7;
        bus.wd_i = 5'd3; bus.wreg_i = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        chk("flush pre stall", {31'b0, bus.stall_req_o}, 32'd1);
        bus.flush_i = 1'b1; bus.valid_i = 1'b0;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        chk("flush stall", {31'b0, bus.stall_req_o}, 32'd0);
        chk("flush valid_o", {31'b0, bus.valid_o}, 32'd0);
        chk("flush wreg_o", {31'b0, bus.wreg_o}, 32'd0);
        chk("flush wdata_o", bus.wdata_o, 32'd0);
        spurious = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.valid_o || bus.wreg_o) spurious++; end
        chk("flush no write", spurious, 0);
        $display("flush sequence: spurious writes=%0d", spurious);
        run_op(8'h01, 32'd1, 32'd2, 5'd4, 1'b1, lat, stalls, data, wdo, wro, got);
        $display("post-flush ADD -> wdata=%h lat=%0d", data, lat);
        chk("post-flush add", data, 32'd3);
        chk("post-flush lat", lat, 1);

        // reset in the middle of a MUL
        bus.valid_i = 1'b1; bus.aluop_i = 8'h10; bus.reg1_i = 32'd3; bus.reg2_i = 32'd5;
        bus.wd_i = 5'd2; bus.wreg_i = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1; bus.valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("mid-MUL reset: stall=%b valid=%b wdata=%h", bus.stall_req_o, bus.valid_o, bus.wdata_o);
        chk("rst stall", {31'b0, bus.stall_req_o}, 32'd0);
        chk("rst valid_o", {31'b0, bus.valid_o}, 32'd0);
        chk("rst wreg_o", {31'b0, bus.wreg_o}, 32'd0);
        chk("rst wd_o", {27'b0, bus.wd_o}, 32'd0);
        chk("rst wdata_o", bus.wdata_o, 32'd0);
        spurious = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.valid_o) spurious++; end
        chk("rst no write", spurious, 0);

        // XLEN=8 instance: MUL 0x0F x 0x11
        bus8.valid_i = 1'b1; bus8.aluop_i = 8'h10; bus8.reg1_i = 8'h0F; bus8.reg2_i = 8'h11;
        bus8.wd_i = 5'd9; bus8.wreg_i = 1'b1;
        lat = 0; stalls = 0; got = 1'b0; data = '0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            st = bus8.stall_req_o;
            if (st) stalls++;
            @(posedge clk); #1;
            lat++;
            if (!st) bus8.valid_i = 1'b0;
            if (bus8.valid_o) begin got = 1'b1; data = {24'b0, bus8.wdata_o}; end
        end
        bus8.valid_i = 1'b0;
        $display("xlen8 MUL -> wdata=%h lat=%0d stalls=%0d", data, lat, stalls);
        chk("x8 valid", {31'b0, got}, 32'd1);
        chk("x8 wdata", data, 32'h0000_00FF);
        chk("x8 latency", lat, 10);
        chk("x8 stalls", stalls, 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised execute stage for the RISC-V core. It runs the RV32I integer ALU ops in one cycle and the M-extension multiply/divide ops as an iterative multi-cycle unit. It sits between the ID/EX register and the MEM stage. Its results are registered at its output, and it raises a stall request to freeze the upstream pipeline while a multiply or divide is in progress.

## Interface
- XLEN, 32: datapath width; power of two, minimum 8.
- REG_ADDR_W, 5: destination register address width.
- OP_W, 8: aluop width.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- valid_i  input  1  the aluop/operand inputs hold a real instruction.
- aluop_i  input  OP_W  operation code (see Operation).
- reg1_i  input  XLEN  operand 1 (rs1 or PC-derived).
- reg2_i  input  XLEN  operand 2 (rs2 or immediate).
- wd_i  input  REG_ADDR_W  destination register.
- wreg_i  input  1  instruction writes wd_i.
- flush_i  input  1  synchronous kill of the in-flight instruction.
- stall_req_o  output  1  combinational; upstream must hold its inputs while this is high.
- valid_o  output  XLEN-agnostic 1  registered result valid.
- wd_o  output  REG_ADDR_W  registered destination.
- wreg_o  output  1  registered write enable; equals wreg & valid.
- wdata_o  output  XLEN  registered result.

## Operation
- Opcodes: 0x00 NOP, 0x01 ADD, 0x02 SUB, 0x03 AND, 0x04 OR, 0x05 XOR, 0x06 SLL, 0x07 SRL, 0x08 SRA, 0x09 SLT, 0x0A SLTU.
- M-extension opcodes: 0x10 MUL, 0x11 MULH, 0x12 MULHSU, 0x13 MULHU, 0x14 DIV, 0x15 DIVU, 0x16 REM, 0x17 REMU.
- Unknown opcode: wdata 0, wreg passes through unchanged.
- ALU arithmetic is mod 2^XLEN.
- Shift amount is reg2_i[$clog2(XLEN)-1:0].
- SLT/SLTU results are zero-extended to XLEN.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE + valid_i + ALU op: result registered at the edge; stall_req_o=0.
- IDLE + valid_i + mul op:
  - Capture the operand magnitudes, using each operand's sign per op.
  - Record the result sign, load a counter with XLEN, go to MUL.
- IDLE + valid_i + div op: capture the same way, then go to DIV.
- Div by zero: skip DIV and go straight to DONE.
  - Quotient is all-ones (DIV/DIVU).
  - Remainder equals the dividend (REM/REMU).
- Signed overflow (DIV/REM of -2^(XLEN-1) by -1): skip to DONE with quotient -2^(XLEN-1) and remainder 0.
- MUL state: radix-2 shift-add, one bit per cycle, into a 2·XLEN accumulator.
- DIV state: restoring division, one quotient bit per cycle.
- Leaving MUL/DIV: the counter decrements each edge, and the state moves to DONE when it reaches 0.
- DONE: apply the negation if the result sign is set, and select the output word:
  - MUL: low half of the product.
  - MULH*: high half of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder, with the sign of the dividend.
- DONE exit: the result is registered onto wdata_o/valid_o at the edge, and the state returns to IDLE.
- In DONE, the upstream inputs still hold the same M instruction; they are consumed, not restarted.
- stall_req_o is 1 in these cases, 0 otherwise:
  - IDLE with valid_i and an M op.
  - The whole of MUL or DIV.
- flush_i (or rst) at any edge has these effects:
  - State goes to IDLE and the counter clears.
  - valid_o, wreg_o, wd_o and wdata_o all go to 0 next cycle.
  - flush_i takes priority over a new valid_i in the same cycle.
- valid_i=0 in IDLE: valid_o=0 and wreg_o=0 next cycle; wdata_o=0.

## Timing
- Reset values: valid_o=0, wreg_o=0, wd_o=0, wdata_o=0, stall_req_o=0, state IDLE.
- ALU op presented in cycle T: outputs are valid in T+1 (latency 1, throughput 1 per cycle).
- Normal mul/div op presented in cycle T:
  - stall_req_o is high in cycles T..T+XLEN, and low in T+XLEN+1 (DONE).
  - Outputs are valid in T+XLEN+2.
- Special-case div (zero divisor or overflow):
  - stall_req_o is high in T only.
  - DONE occurs in T+1, and outputs are valid in T+2.
- Back-to-back M ops: the second is presented in the cycle after DONE and starts from IDLE. No overlap.
- No downstream backpressure: the MEM stage always accepts.

## Test plan
- Reset, then ORs: rst high 2 cycles → all outputs 0.
  - OR 0xF0F0_0000 | 0x0000_0F0F, wd=5, wreg=1 → next cycle wdata_o=0xF0F0_0F0F, wd_o=5, wreg_o=1, valid_o=1.
  - Then SRA 0x8000_0000 by 4 → 0xF800_0000.
- MULH -3 × 5 (XLEN=32) → stall_req_o high for 33 cycles, result 0xFFFF_FFFF 34 cycles after issue.
  - MUL of the same operands → 0xFFFF_FFF1.
  - MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE.
- DIV -7 / 2 → 0xFFFF_FFFD.
  - REM -7 / 2 → 0xFFFF_FFFF.
  - DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- Div-by-zero DIVU 9 / 0 → 0xFFFF_FFFF and REMU 9 / 0 → 9, each with a single stall cycle.
  - DIV 0x8000_0000 / -1 → 0x8000_0000, and REM of the same → 0.
- flush_i at iteration 10 of a DIV → stall_req_o drops the same cycle (comb from IDLE next), valid_o=0, no spurious write.
  - A following ADD 1 + 2 → 3 after 1 cycle.
- rst mid-MUL → all outputs 0, stall_req_o 0 next cycle.
  - Rerun at XLEN=8: MUL 0x0F × 0x11 → 0xFF, outputs valid 10 cycles after issue.
